// File: rtl/hazard_scoreboard_if.sv
// Decode-stage hazard bus: operand/stage descriptors in, forwarding selects,
// stall and multiply status out.
interface hazard_scoreboard_if #(
    parameter int unsigned AW    = 5,
    parameter int unsigned NSRC  = 2,
    parameter int unsigned DEPTH = 3,
    parameter int unsigned SW    = $clog2(DEPTH + 2)
);
    logic [NSRC*AW-1:0]  src_addr;
    logic [AW-1:0]       dec_dest;
    logic                dec_regwrite;
    logic                mul_issue;
    logic [DEPTH*AW-1:0] stg_dest;
    logic [DEPTH-1:0]    stg_regwrite;
    logic [DEPTH-1:0]    stg_memtoreg;
    logic                flush;
    logic [NSRC*SW-1:0]  fwd_sel;
    logic                stall;
    logic                mul_busy;
    logic                mul_done;
    logic [AW-1:0]       mul_dest;
    logic [31:0]         stall_count;

    modport master (
        output src_addr, dec_dest, dec_regwrite, mul_issue,
               stg_dest, stg_regwrite, stg_memtoreg, flush,
        input  fwd_sel, stall, mul_busy, mul_done, mul_dest, stall_count
    );

    modport slave (
        input  src_addr, dec_dest, dec_regwrite, mul_issue,
               stg_dest, stg_regwrite, stg_memtoreg, flush,
        output fwd_sel, stall, mul_busy, mul_done, mul_dest, stall_count
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Decode-stage data-hazard unit: per-operand forwarding select, load-use and
// multiply stalls, one-entry multiply scoreboard and saturating stall counter.
module hazard_scoreboard #(
    parameter int unsigned AW         = 5,
    parameter int unsigned NSRC       = 2,
    parameter int unsigned DEPTH      = 3,
    parameter int unsigned LOAD_STAGE = 2,
    parameter int unsigned MUL_LAT    = 4,
    parameter int unsigned SW         = $clog2(DEPTH + 2)
) (
    input  logic               clock,
    input  logic               reset,
    hazard_scoreboard_if.slave sb
);
    localparam int unsigned CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic [SW-1:0] SEL_MUL   = SW'(DEPTH + 1);
    localparam logic [CW-1:0] CNT_START = CW'(MUL_LAT - 1);

    logic [0:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [AW-1:0]      mdest_q, mdest_d;
    logic [31:0]        stall_cnt_q;

    logic               mul_busy_c;
    logic               mul_done_c;
    logic               mul_pending_c;
    logic               stall_c;
    logic               accept_c;
    logic [NSRC*SW-1:0] sel_c;
    logic [AW-1:0]      src;
    logic               hit;

    assign mul_busy_c    = (state_q == ST_BUSY);
    assign mul_done_c    = mul_busy_c && (cnt_q == '0);
    assign mul_pending_c = mul_busy_c && !mul_done_c;

    // Operand resolution: pending multiply, then multiply result, then nearest stage.
    always_comb begin
        sel_c   = '0;
        stall_c = 1'b0;
        src     = '0;
        hit     = 1'b0;
        for (int i = 0; i < int'(NSRC); i++) begin
            src = sb.src_addr[i*AW +: AW];
            hit = 1'b0;
            if (src != '0) begin
                if (mul_pending_c && (src == mdest_q)) begin
                    stall_c = 1'b1;
                end else if (mul_done_c && (src == mdest_q)) begin
                    sel_c[i*SW +: SW] = SEL_MUL;
                end else begin
                    for (int k = 0; k < int'(DEPTH); k++) begin
                        if (!hit && sb.stg_regwrite[k] && (sb.stg_dest[k*AW +: AW] == src)) begin
                            hit = 1'b1;
                            // Load data not yet available this close to decode.
                            if (sb.stg_memtoreg[k] && ((k + 1) < int'(LOAD_STAGE))) begin
                                stall_c = 1'b1;
                            end else begin
                                sel_c[i*SW +: SW] = SW'(k + 1);
                            end
                        end
                    end
                end
            end
        end
        if (sb.dec_regwrite && (sb.dec_dest != '0) && mul_pending_c && (sb.dec_dest == mdest_q)) begin
            stall_c = 1'b1;
        end
        // Multiplier is single-entry, including its done cycle.
        if (sb.mul_issue && mul_busy_c) begin
            stall_c = 1'b1;
        end
    end

    assign accept_c = sb.mul_issue && !stall_c && !sb.flush;

    // Multiply scoreboard next state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mdest_d = mdest_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    state_d = ST_BUSY;
                    cnt_d   = CNT_START;
                    mdest_d = sb.dec_dest;
                end
            end
            ST_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mdest_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mdest_q <= mdest_d;
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (stall_c && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign sb.fwd_sel     = sel_c;
    assign sb.stall       = stall_c;
    assign sb.mul_busy    = mul_busy_c;
    assign sb.mul_done    = mul_done_c;
    assign sb.mul_dest    = mdest_q;
    assign sb.stall_count = stall_cnt_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: table of forwarding vectors plus
// multiply, flush, reset and counter-saturation sequences.
module tb_hazard_scoreboard;
    localparam int unsigned AW    = 5;
    localparam int unsigned NSRC  = 2;
    localparam int unsigned DEPTH = 3;
    localparam int unsigned SW    = 3;

    typedef struct {
        logic [4:0]  src0, src1, dec_dest;
        logic        dec_rw, issue, flush;
        logic [14:0] sdest;
        logic [2:0]  srw, smem;
        logic        chk_sel;
        logic [2:0]  sel0, sel1;
        logic        stall, busy, done;
        logic [4:0]  mdest;
    } vec_t;

    logic clock;
    logic reset;
    hazard_scoreboard_if #(.AW(AW), .NSRC(NSRC), .DEPTH(DEPTH), .SW(SW)) sb_if ();

    hazard_scoreboard dut (
        .clock (clock),
        .reset (reset),
        .sb    (sb_if.slave)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] model_count = 32'd0;
    vec_t        exp_q[$];
    vec_t        tbl[$];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(
        input logic [4:0] src0, src1, dec_dest, input logic dec_rw, issue, flush,
        input logic [14:0] sdest, input logic [2:0] srw, smem,
        input logic chk_sel, input logic [2:0] sel0, sel1,
        input logic stall, busy, done, input logic [4:0] mdest);
        vec_t v;
        v.src0 = src0; v.src1 = src1; v.dec_dest = dec_dest;
        v.dec_rw = dec_rw; v.issue = issue; v.flush = flush;
        v.sdest = sdest; v.srw = srw; v.smem = smem;
        v.chk_sel = chk_sel; v.sel0 = sel0; v.sel1 = sel1;
        v.stall = stall; v.busy = busy; v.done = done; v.mdest = mdest;
        return v;
    endfunction

    function automatic vec_t idle(input logic busy, done, input logic [4:0] mdest);
        return mk(0, 0, 0, 0, 0, 0, 15'd0, 3'b000, 3'b000, 1, 0, 0, 0, busy, done, mdest);
    endfunction

    task automatic cmp(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0h want %0h", name, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        sb_if.src_addr     = {v.src1, v.src0};
        sb_if.dec_dest     = v.dec_dest;
        sb_if.dec_regwrite = v.dec_rw;
        sb_if.mul_issue    = v.issue;
        sb_if.flush        = v.flush;
        sb_if.stg_dest     = v.sdest;
        sb_if.stg_regwrite = v.srw;
        sb_if.stg_memtoreg = v.smem;
    endtask

    // Drive one cycle just after the edge, compare at the falling edge.
    task automatic drive_cycle(input vec_t v, input int idx);
        vec_t e;
        logic [5:0] sel;
        @(posedge clock);
        #1;
        apply(v);
        exp_q.push_back(v);
        @(negedge clock);
        e   = exp_q.pop_front();
        sel = sb_if.fwd_sel;
        cmp("stall", idx, 32'(sb_if.stall), 32'(e.stall));
        if (e.chk_sel) begin
            cmp("sel0", idx, 32'(sel[2:0]), 32'(e.sel0));
            cmp("sel1", idx, 32'(sel[5:3]), 32'(e.sel1));
        end
        cmp("mul_busy", idx, 32'(sb_if.mul_busy), 32'(e.busy));
        cmp("mul_done", idx, 32'(sb_if.mul_done), 32'(e.done));
        cmp("mul_dest", idx, 32'(sb_if.mul_dest), 32'(e.mdest));
        cmp("stall_count", idx, sb_if.stall_count, model_count);
        if (e.stall && (model_count != 32'hFFFF_FFFF)) model_count = model_count + 32'd1;
    endtask

    initial begin
        reset = 1'b1;
        apply(idle(0, 0, 0));

        // Forwarding table, multiplier idle throughout.
        tbl.push_back(mk(5, 0, 0, 0, 0, 0, {5'd5, 5'd0, 5'd5}, 3'b101, 3'b000, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(7, 0, 0, 0, 0, 0, {5'd0, 5'd0, 5'd7}, 3'b001, 3'b001, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(7, 0, 0, 0, 0, 0, {5'd0, 5'd7, 5'd0}, 3'b010, 3'b010, 1, 2, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, {5'd0, 5'd0, 5'd0}, 3'b111, 3'b000, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(3, 4, 0, 0, 0, 0, {5'd4, 5'd3, 5'd3}, 3'b110, 3'b100, 1, 2, 3, 0, 0, 0, 0));
        tbl.push_back(mk(6, 0, 0, 0, 0, 0, {5'd0, 5'd6, 5'd6}, 3'b011, 3'b001, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 8, 0, 0, 0, 0, {5'd8, 5'd8, 5'd0}, 3'b110, 3'b010, 1, 0, 2, 0, 0, 0, 0));
        tbl.push_back(mk(10, 11, 0, 0, 0, 0, {5'd12, 5'd2, 5'd1}, 3'b111, 3'b000, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(13, 13, 0, 0, 0, 0, {5'd0, 5'd0, 5'd13}, 3'b001, 3'b000, 1, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(5, 0, 5, 1, 0, 0, {5'd5, 5'd0, 5'd0}, 3'b100, 3'b100, 1, 3, 0, 0, 0, 0, 0));
        tbl.push_back(mk(2, 3, 0, 0, 0, 0, {5'd0, 5'd2, 5'd3}, 3'b011, 3'b001, 0, 0, 0, 1, 0, 0, 0));

        #12;
        cmp("rst_fwd_sel", 0, 32'(sb_if.fwd_sel), 32'd0);
        cmp("rst_stall", 0, 32'(sb_if.stall), 32'd0);
        cmp("rst_mul_busy", 0, 32'(sb_if.mul_busy), 32'd0);
        cmp("rst_mul_done", 0, 32'(sb_if.mul_done), 32'd0);
        cmp("rst_mul_dest", 0, 32'(sb_if.mul_dest), 32'd0);
        cmp("rst_stall_count", 0, sb_if.stall_count, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        foreach (tbl[i]) drive_cycle(tbl[i], i);

        // RAW on a pending multiply to r9, then forward its result.
        drive_cycle(mk(0, 0, 9, 1, 1, 0, 15'd0, 3'b000, 3'b000, 1, 0, 0, 0, 0, 0, 0), 100);
        for (int c = 0; c < 3; c++)
            drive_cycle(mk(9, 0, 0, 0, 0, 0, 15'd0, 3'b000, 3'b000, 0, 0, 0, 1, 1, 0, 9), 101 + c);
        drive_cycle(mk(9, 0, 0, 0, 0, 0, 15'd0, 3'b000, 3'b000, 1, 4, 0, 0, 1, 1, 9), 104);
        drive_cycle(mk(9, 0, 0, 0, 0, 0, 15'd0, 3'b000, 3'b000, 1, 0, 0, 0, 0, 0, 9), 105);

        // WAW, then a structural conflict held through the done cycle.
        drive_cycle(mk(0, 0, 9, 1, 1, 0, 15'd0, 3'b000, 3'b000, 1, 0, 0, 0, 0, 0, 9), 200);
        drive_cycle(mk(0, 0, 9, 1, 0, 0, 15'd0, 3'b000, 3'b000, 1, 0, 0, 1, 1, 0, 9), 201);
        drive_cycle(mk(0, 0, 10, 1, 1, 0, 15'd0, 3'b000, 3'b000, 1, 0, 0, 1, 1, 0, 9), 202);
        drive_cycle(mk(0, 0, 10, 1, 1, 1, 15'd0, 3'b000, 3'b000, 1, 0, 0, 1, 1, 0, 9), 203);
        drive_cycle(mk(0, 0, 10, 1, 1, 0, 15'd0, 3'b000, 3'b000, 1, 0, 0, 1, 1, 1, 9), 204);
        drive_cycle(mk(0, 0, 10, 1, 1, 0, 15'd0, 3'b000, 3'b000, 1, 0, 0, 0, 0, 0, 9), 205);
        for (int c = 0; c < 3; c++) drive_cycle(idle(1, 0, 10), 206 + c);
        drive_cycle(idle(1, 1, 10), 209);
        drive_cycle(idle(0, 0, 10), 210);

        // Flush suppresses the accept.
        drive_cycle(mk(0, 0, 11, 1, 1, 1, 15'd0, 3'b000, 3'b000, 1, 0, 0, 0, 0, 0, 10), 300);
        drive_cycle(idle(0, 0, 10), 301);

        // Reset two cycles after an accept.
        drive_cycle(mk(0, 0, 12, 1, 1, 0, 15'd0, 3'b000, 3'b000, 1, 0, 0, 0, 0, 0, 10), 400);
        drive_cycle(idle(1, 0, 12), 401);
        @(posedge clock);
        #1;
        apply(idle(0, 0, 0));
        #1;
        reset = 1'b1;
        #1;
        cmp("mid_rst_mul_busy", 402, 32'(sb_if.mul_busy), 32'd0);
        cmp("mid_rst_mul_done", 402, 32'(sb_if.mul_done), 32'd0);
        cmp("mid_rst_mul_dest", 402, 32'(sb_if.mul_dest), 32'd0);
        cmp("mid_rst_stall_count", 402, sb_if.stall_count, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        model_count = 32'd0;
        for (int c = 0; c < 6; c++) drive_cycle(idle(0, 0, 0), 403 + c);

        // Counter saturation from a preloaded value.
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_q;
        model_count = 32'hFFFF_FFFE;
        for (int c = 0; c < 3; c++)
            drive_cycle(mk(7, 0, 0, 0, 0, 0, {5'd0, 5'd0, 5'd7}, 3'b001, 3'b001, 0, 0, 0, 1, 0, 0, 0), 500 + c);
        drive_cycle(idle(0, 0, 0), 503);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Generalised data-hazard unit for the in-order pipeline, driving the decode-stage operand muxes.
- Per source operand it picks forwarding from any of DEPTH downstream buffers, the register file, or a multi-cycle multiply result.
- Generates stalls for load-use, RAW on a pending multiply, WAW on a pending multiply, and multiply structural conflicts.
- Keeps a one-entry multiply scoreboard and a saturating stall counter.

Parameters:
- AW, 5, register address width; register 0 is hardwired zero.
- NSRC, 2, number of source operands checked per decoded instruction.
- DEPTH, 3, forwardable stages after decode; stage 1 = execute output, stage DEPTH = writeback buffer.
- LOAD_STAGE, 2, first stage index whose data is valid for a load (memtoreg) instruction.
- MUL_LAT, 4, multiply latency in cycles (>=1).
- SW, $clog2(DEPTH+2), forwarding select width.

Ports:
- clock  in  1  pipeline clock.
- reset  in  1  asynchronous, active-high.
- src_addr  in  NSRC*AW  packed decode source registers; operand i is at [i*AW +: AW].
- dec_dest  in  AW  decode destination register.
- dec_regwrite  in  1  decoded instruction writes a register.
- mul_issue  in  1  decoded instruction is a multiply.
- stg_dest  in  DEPTH*AW  destination register of stage k at [(k-1)*AW +: AW].
- stg_regwrite  in  DEPTH  register-write flag, one bit per stage.
- stg_memtoreg  in  DEPTH  load flag, one bit per stage.
- flush  in  1  taken-jump squash of the decode instruction.
- fwd_sel  out  NSRC*SW  per-operand select: 0 = register file, k = stage k, DEPTH+1 = multiply result.
- stall  out  1  hold fetch/decode and inject a bubble.
- mul_busy  out  1  multiply in flight.
- mul_done  out  1  multiply result valid this cycle.
- mul_dest  out  AW  multiply destination register.
- stall_count  out  32  saturating count of stalled cycles.

Behaviour:
- Reset (asynchronous): mul_busy=0, mul_cnt=0, mul_dest=0, stall_count=0. Combinational outputs then read fwd_sel=0, stall=0 (for inputs without stage matches), mul_done=0.
- A source operand with address 0 never matches, never stalls, and gets fwd_sel=0.
- Per-operand priority, highest first:
  1. mul_busy && !mul_done && src==mul_dest -> stall.
  2. mul_done && src==mul_dest -> sel DEPTH+1. The multiply is younger than any in-pipe writer, so it wins.
  3. Nearest stage k (smallest k) with stg_regwrite[k] && stg_dest[k]==src -> sel k. If stg_memtoreg[k] && k<LOAD_STAGE -> stall instead.
  4. Otherwise -> sel 0.
- A farther stage never overrides a nearer match, even if the nearer match stalls.
- WAW: dec_regwrite && dec_dest!=0 && mul_busy && !mul_done && dec_dest==mul_dest -> stall.
- Structural: mul_issue && mul_busy -> stall. This includes the mul_done cycle, so a back-to-back multiply waits one extra cycle.
- stall is the OR of all conditions above and is purely combinational from the inputs and the state.
- Multiply accept: mul_issue && !stall && !flush at a clock edge sets mul_busy=1, mul_dest=dec_dest, mul_cnt=MUL_LAT-1.
- While busy, mul_cnt decrements each cycle. mul_done = mul_busy && mul_cnt==0.
- At the edge ending the mul_done cycle, mul_busy clears.
- Timing: accept edge ends cycle T; mul_done is high in cycle T+MUL_LAT, for exactly one cycle.
- flush suppresses accept in its cycle only. An already-accepted multiply always completes.
- flush does not mask stall.
- stall_count increments on every cycle with stall=1 and saturates at 0xFFFFFFFF.
- Reset mid-multiply: mul_busy drops immediately, mul_done is never asserted, and the pending register is released.

Test Plan:
- Src1=5, stage1 regwrite dest 5 (not a load), stage3 also dest 5 -> fwd_sel op0=1, stall=0.
- Src1=7, stage1 load dest 7, LOAD_STAGE=2 -> stall=1. Next cycle the load moves to stage2 -> fwd_sel=2, stall=0, stall_count=1.
- Multiply accepted dest 9 at T. A later instruction reading r9 stalls in cycles T+1..T+3; in T+4 mul_done=1, fwd_sel=4 (DEPTH+1), stall=0.
- Multiply pending dest 9, decode has regwrite dest 9 -> stall (WAW). Second mul_issue while busy -> stall until the cycle after mul_done.
- mul_issue with flush=1 -> no accept, mul_busy stays 0. Reset asserted two cycles after an accept -> mul_busy=0 immediately, mul_done never pulses.
- Src=0 with every stage writing dest 0 -> fwd_sel=0, stall=0. Forcing stall to run past 2^32 cycles (preload via force) -> stall_count holds at 0xFFFFFFFF.
